// File: rtl/round_robin_wrr_table.sv
// Weighted round-robin arbiter driven by a programmable table of (queue, weight) entries.
// Grants go out as selector/selector_enb and are taken only when pop_ready is also high.
module round_robin_wrr_table #(
    parameter int QUEUE_QUANTITY  = 4,
    parameter int TABLE_SIZE      = 8,
    parameter int WEIGHT_BITS     = 6,
    parameter int WORK_CONSERVING = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        enb,
    input  logic                                        cfg_load,
    input  logic [TABLE_SIZE*WEIGHT_BITS-1:0]           pesos,
    input  logic [TABLE_SIZE*$clog2(QUEUE_QUANTITY)-1:0] selecciones,
    input  logic [QUEUE_QUANTITY-1:0]                   buf_empty,
    input  logic                                        pop_ready,
    output logic [$clog2(QUEUE_QUANTITY)-1:0]           selector,
    output logic                                        selector_enb,
    output logic [$clog2(TABLE_SIZE)-1:0]               entry_idx
);

    localparam int QW = $clog2(QUEUE_QUANTITY);
    localparam int PW = $clog2(TABLE_SIZE);

    // Handshake: selector_enb is the valid, pop_ready the ready; a grant is consumed
    // (and counted against the entry quota) only in a cycle where both are high.

    logic [WEIGHT_BITS-1:0] tbl_w_q [TABLE_SIZE];
    logic [WEIGHT_BITS-1:0] tbl_w_d [TABLE_SIZE];
    logic [QW-1:0]          tbl_s_q [TABLE_SIZE];
    logic [QW-1:0]          tbl_s_d [TABLE_SIZE];
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [WEIGHT_BITS-1:0] used_q, used_d;

    logic [TABLE_SIZE-1:0]  elig;
    logic [PW-1:0]          cand;
    logic                   cand_valid;
    logic [PW:0]            scan_idx;
    logic                   grant;
    logic [WEIGHT_BITS-1:0] base;
    logic [WEIGHT_BITS-1:0] base_inc;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(TABLE_SIZE - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // The table keeps capturing for as long as reset or cfg_load is held.
    always_comb begin
        for (int n = 0; n < TABLE_SIZE; n++) begin
            tbl_w_d[n] = tbl_w_q[n];
            tbl_s_d[n] = tbl_s_q[n];
            if (!rst || cfg_load) begin
                tbl_w_d[n] = pesos[n*WEIGHT_BITS +: WEIGHT_BITS];
                tbl_s_d[n] = selecciones[n*QW +: QW];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < TABLE_SIZE; n++) begin
            elig[n] = (tbl_w_q[n] != '0) && !buf_empty[tbl_s_q[n]];
        end
    end

    // Scan downwards so the entry closest to ptr (smallest offset) wins last.
    always_comb begin
        cand       = ptr_q;
        cand_valid = 1'b0;
        scan_idx   = '0;
        if (WORK_CONSERVING != 0) begin
            for (int k = TABLE_SIZE - 1; k >= 0; k--) begin
                scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
                if (scan_idx >= (PW+1)'(TABLE_SIZE)) begin
                    scan_idx = scan_idx - (PW+1)'(TABLE_SIZE);
                end
                if (elig[scan_idx[PW-1:0]]) begin
                    cand       = scan_idx[PW-1:0];
                    cand_valid = 1'b1;
                end
            end
        end else begin
            cand_valid = elig[ptr_q];
        end
    end

    always_comb begin
        selector_enb = rst && enb && !cfg_load && cand_valid;
        selector     = selector_enb ? tbl_s_q[cand] : '0;
        entry_idx    = rst ? ptr_q : '0;
    end

    always_comb begin
        ptr_d    = ptr_q;
        used_d   = used_q;
        grant    = selector_enb && pop_ready;
        base     = (cand == ptr_q) ? used_q : '0;
        base_inc = base + WEIGHT_BITS'(1);
        if (cfg_load) begin
            ptr_d  = '0;
            used_d = '0;
        end else if (grant) begin
            if (base_inc == tbl_w_q[cand]) begin
                ptr_d  = wrap_inc(cand);
                used_d = '0;
            end else begin
                ptr_d  = cand;
                used_d = base_inc;
            end
        end else if (enb && (WORK_CONSERVING == 0) && !elig[ptr_q]) begin
            // Non-work-conserving: an ineligible entry costs exactly one idle cycle.
            ptr_d  = wrap_inc(ptr_q);
            used_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < TABLE_SIZE; n++) begin
            tbl_w_q[n] <= tbl_w_d[n];
            tbl_s_q[n] <= tbl_s_d[n];
        end
        if (!rst) begin
            ptr_q  <= '0;
            used_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            used_q <= used_d;
        end
    end

endmodule

// File: tb/tb_round_robin_wrr_table.sv
// Bench for round_robin_wrr_table: work-conserving and non-work-conserving instances share
// stimulus; a table-level model predicts every cycle's outputs into per-instance queues.
module tb_round_robin_wrr_table;

    localparam int TS = 8;
    localparam int QQ = 4;
    localparam int WB = 6;
    localparam int QW = 2;
    localparam int PW = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                enb = 1'b1;
    logic                cfg_load = 1'b0;
    logic [TS*WB-1:0]    pesos = '0;
    logic [TS*QW-1:0]    selecciones = '0;
    logic [QQ-1:0]       buf_empty = '0;
    logic                pop_ready = 1'b1;

    logic [QW-1:0]       sel0, sel1;
    logic                se0, se1;
    logic [PW-1:0]       idx0, idx1;

    round_robin_wrr_table #(.QUEUE_QUANTITY(QQ), .TABLE_SIZE(TS), .WEIGHT_BITS(WB),
                            .WORK_CONSERVING(1)) dut_wc (
        .clk(clk), .rst(rst), .enb(enb), .cfg_load(cfg_load), .pesos(pesos),
        .selecciones(selecciones), .buf_empty(buf_empty), .pop_ready(pop_ready),
        .selector(sel0), .selector_enb(se0), .entry_idx(idx0));

    round_robin_wrr_table #(.QUEUE_QUANTITY(QQ), .TABLE_SIZE(TS), .WEIGHT_BITS(WB),
                            .WORK_CONSERVING(0)) dut_nwc (
        .clk(clk), .rst(rst), .enb(enb), .cfg_load(cfg_load), .pesos(pesos),
        .selecciones(selecciones), .buf_empty(buf_empty), .pop_ready(pop_ready),
        .selector(sel1), .selector_enb(se1), .entry_idx(idx1));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q0[$];
    logic [5:0] exp_q1[$];
    int log0[$];
    int log1[$];
    int exp_l[$];
    bit log_on = 1'b0;

    // ---------------- reference model ----------------
    int mw[TS];
    int ms[TS];
    int mptr[2];
    int mused[2];
    logic [TS*WB-1:0] cur_pw = '0;
    logic [TS*QW-1:0] cur_ps = '0;
    int tw[TS];
    int tsel[TS];

    function automatic bit melig(input int n);
        return (mw[n] != 0) && !buf_empty[ms[n]];
    endfunction

    task automatic set_tbl();
        for (int n = 0; n < TS; n++) begin
            cur_pw[n*WB +: WB] = WB'(tw[n]);
            cur_ps[n*QW +: QW] = QW'(tsel[n]);
        end
    endtask

    // One clock cycle: drive inputs, predict both instances' outputs, advance the model.
    task automatic step(input bit r, input bit e, input bit l, input bit p, input logic [3:0] emp);
        int nptr[2];
        int nused[2];
        @(posedge clk);
        #1;
        rst = r; enb = e; cfg_load = l; pop_ready = p; buf_empty = emp;
        pesos = cur_pw; selecciones = cur_ps;
        for (int m = 0; m < 2; m++) begin
            int cand;
            bit cv;
            bit oe;
            int os;
            int oi;
            int base;
            logic [5:0] v;
            cand = mptr[m];
            cv = 1'b0;
            if (m == 0) begin
                for (int k = 0; k < TS; k++) begin
                    int n;
                    n = (mptr[m] + k) % TS;
                    if (!cv && melig(n)) begin
                        cand = n;
                        cv = 1'b1;
                    end
                end
            end else begin
                cv = melig(mptr[m]);
            end
            oe = r && e && !l && cv;
            os = oe ? ms[cand] : 0;
            oi = r ? mptr[m] : 0;
            v = {oe, QW'(os), PW'(oi)};
            if (m == 0) exp_q0.push_back(v);
            else exp_q1.push_back(v);
            nptr[m] = mptr[m];
            nused[m] = mused[m];
            if (!r || l) begin
                nptr[m] = 0;
                nused[m] = 0;
            end else if (oe && p) begin
                base = (cand == mptr[m]) ? mused[m] : 0;
                if (base + 1 == mw[cand]) begin
                    nptr[m] = (cand + 1) % TS;
                    nused[m] = 0;
                end else begin
                    nptr[m] = cand;
                    nused[m] = base + 1;
                end
            end else if (e && m == 1 && !melig(mptr[m])) begin
                nptr[m] = (mptr[m] + 1) % TS;
                nused[m] = 0;
            end
        end
        for (int m = 0; m < 2; m++) begin
            mptr[m] = nptr[m];
            mused[m] = nused[m];
        end
        if (!r || l) begin
            for (int n = 0; n < TS; n++) begin
                mw[n] = int'(cur_pw[n*WB +: WB]);
                ms[n] = int'(cur_ps[n*QW +: QW]);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic log_start();
        @(negedge clk);
        #1;
        log0.delete();
        log1.delete();
        log_on = 1'b1;
    endtask

    task automatic log_stop();
        @(negedge clk);
        #1;
        log_on = 1'b0;
    endtask

    task automatic check_log(input string name, input bit which);
        int got[$];
        if (which) got = log1;
        else got = log0;
        chk({name, "_count"}, got.size(), exp_l.size());
        for (int i = 0; i < got.size() && i < exp_l.size(); i++) begin
            chk($sformatf("%s_grant%0d", name, i), got[i], exp_l[i]);
        end
    endtask

    task automatic load_a();
        tw   = '{3, 1, 2, 1, 0, 0, 0, 0};
        tsel = '{0, 1, 2, 3, 0, 0, 0, 0};
        set_tbl();
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) begin
                logic [5:0] v;
                v = exp_q0.pop_front();
                checks++;
                if ({se0, sel0, idx0} !== v) begin
                    errors++;
                    $display("FAIL wc_out t=%0t actual enb/sel/idx=%b/%0d/%0d expected=%b/%0d/%0d",
                             $time, se0, sel0, idx0, v[5], v[4:3], v[2:0]);
                end
            end
            if (exp_q1.size() > 0) begin
                logic [5:0] v;
                v = exp_q1.pop_front();
                checks++;
                if ({se1, sel1, idx1} !== v) begin
                    errors++;
                    $display("FAIL nwc_out t=%0t actual enb/sel/idx=%b/%0d/%0d expected=%b/%0d/%0d",
                             $time, se1, sel1, idx1, v[5], v[4:3], v[2:0]);
                end
            end
            if (log_on) begin
                if (se0 && pop_ready) log0.push_back(int'(sel0));
                if (se1 && pop_ready) log1.push_back(int'(sel1));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        load_a();

        // Reset held with everything eligible, then the weighted order with wrap.
        repeat (3) step(0, 1, 0, 1, 4'h0);
        log_start();
        repeat (10) step(1, 1, 0, 1, 4'h0);
        log_stop();
        exp_l = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        check_log("order_wc", 0);
        exp_l = '{0, 0, 0, 1, 2, 2, 3};
        check_log("order_nwc", 1);

        // Queue 1 empty: skipped without idle (wc) or with one idle cycle (nwc).
        step(1, 1, 1, 1, 4'h0);
        log_start();
        repeat (7) step(1, 1, 0, 1, 4'h2);
        log_stop();
        exp_l = '{0, 0, 0, 2, 2, 3, 0};
        check_log("skip_wc", 0);
        exp_l = '{0, 0, 0, 2, 2, 3};
        check_log("skip_nwc", 1);

        // Backpressure after the second grant of entry 0.
        step(1, 1, 1, 1, 4'h0);
        log_start();
        repeat (2) step(1, 1, 0, 1, 4'h0);
        repeat (3) step(1, 1, 0, 0, 4'h0);
        repeat (2) step(1, 1, 0, 1, 4'h0);
        log_stop();
        exp_l = '{0, 0, 0, 1};
        check_log("bp_wc", 0);
        check_log("bp_nwc", 1);

        // Reload in the middle of entry 2.
        step(1, 1, 1, 1, 4'h0);
        repeat (5) step(1, 1, 0, 1, 4'h0);
        tw   = '{1, 1, 1, 1, 1, 1, 1, 1};
        tsel = '{3, 2, 1, 0, 3, 2, 1, 0};
        set_tbl();
        log_start();
        step(1, 1, 1, 1, 4'h0);
        repeat (9) step(1, 1, 0, 1, 4'h0);
        log_stop();
        exp_l = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
        check_log("reload_wc", 0);
        check_log("reload_nwc", 1);

        // All weights zero, then enable gating with a valid table.
        tw = '{0, 0, 0, 0, 0, 0, 0, 0};
        set_tbl();
        step(1, 1, 1, 1, 4'h0);
        log_start();
        repeat (20) step(1, 1, 0, 1, 4'h0);
        log_stop();
        exp_l.delete();
        check_log("zero_wc", 0);
        check_log("zero_nwc", 1);
        load_a();
        step(1, 1, 1, 1, 4'h0);
        log_start();
        repeat (5) step(1, 0, 0, 1, 4'h0);
        log_stop();
        check_log("enb_off_wc", 0);
        check_log("enb_off_nwc", 1);
        repeat (3) step(1, 1, 0, 1, 4'h0);

        // Full-quota weight on a single entry.
        tw   = '{63, 0, 0, 0, 0, 0, 0, 0};
        tsel = '{2, 0, 0, 0, 0, 0, 0, 0};
        set_tbl();
        step(1, 1, 1, 1, 4'h0);
        log_start();
        repeat (70) step(1, 1, 0, 1, 4'h0);
        log_stop();
        chk("maxw_wc_count", log0.size(), 70);
        chk("maxw_nwc_count", log1.size(), 63);

        // Randomised traffic, reloads and occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit r, e, l, p;
            r = ($urandom_range(0, 59) != 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 24) == 0);
            p = ($urandom_range(0, 3) != 0);
            if (l || !r) begin
                for (int n = 0; n < TS; n++) begin
                    int c;
                    c = int'($urandom_range(0, 9));
                    tw[n] = (c < 3) ? 0 : (c == 9) ? 63 : int'($urandom_range(1, 4));
                    tsel[n] = int'($urandom_range(0, QQ - 1));
                end
                set_tbl();
            end
            step(r, e, l, p, 4'($urandom_range(0, 15)));
        end

        // Drain the expected queues with a bounded wait.
        for (int t = 0; t < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); t++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_wc", exp_q0.size(), 0);
        chk("drain_nwc", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_robin_wrr_table.md
Name: round_robin_wrr_table

Overview:
Parametrised weighted round-robin arbiter driven by a programmable arbitration table. It is the successor to the fixed table round-robin selector in the roundRobin block. Each table entry names a queue and a grant quota (weight). The arbiter steps through the entries and drives the mux select for the FIFO bank that feeds the downstream consumer.
Additions over the previous generation: a ready/valid grant handshake, a selectable work-conserving skip of empty or disabled entries, runtime table reload, and explicit wrap-around.

Parameters:
QUEUE_QUANTITY, 4, number of source FIFOs (at least 2).
TABLE_SIZE, 8, number of arbitration table entries (at least 2; need not be a power of two).
WEIGHT_BITS, 6, width of each entry weight. A weight of 0 disables the entry.
WORK_CONSERVING, 1, 1 = skip ineligible entries in the same cycle; 0 = an ineligible entry forfeits one cycle.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active low.
enb  input  1  arbiter enable; when low there are no grants and state holds.
cfg_load  input  1  when high, reload the table from pesos/selecciones and restart at entry 0.
pesos  input  TABLE_SIZE*WEIGHT_BITS  flat weights; entry n occupies bits [(n+1)*WEIGHT_BITS-1 : n*WEIGHT_BITS].
selecciones  input  TABLE_SIZE*clog2(QUEUE_QUANTITY)  flat queue indices, packed the same way as pesos.
buf_empty  input  QUEUE_QUANTITY  per-queue FIFO empty flags.
pop_ready  input  1  downstream accepts the grant this cycle.
selector  output  clog2(QUEUE_QUANTITY)  granted queue index.
selector_enb  output  1  grant valid.
entry_idx  output  clog2(TABLE_SIZE)  current table pointer (debug).

Behaviour:
- State:
  - Table registers: tbl_w[n] and tbl_s[n].
  - ptr, the current entry, range 0..TABLE_SIZE-1.
  - used, the number of grants already taken from the current entry, WEIGHT_BITS wide.
- Table capture: tbl_w and tbl_s load from pesos/selecciones on every clock while rst=0 or cfg_load=1. They hold otherwise.
- Reset (rst=0 at a rising edge): ptr=0, used=0. While rst=0: selector_enb=0, selector=0, entry_idx=0.
- cfg_load=1 (with rst=1): next-state ptr=0, used=0. selector_enb is forced to 0 that cycle and no grant is taken. A cfg_load mid-entry abandons the remaining quota.
- Eligibility: elig(n) = (tbl_w[n]!=0) and !buf_empty[tbl_s[n]].
- Candidate selection (combinational):
  - WORK_CONSERVING=1: cand is the first eligible entry scanning ptr, ptr+1, … cyclically, with TABLE_SIZE-1 wrapping to 0.
  - WORK_CONSERVING=0: cand=ptr, valid only if elig(ptr).
- Outputs (combinational, zero latency from state and buf_empty):
  - selector_enb = rst & enb & !cfg_load & cand_valid.
  - selector = tbl_s[cand] when selector_enb=1, otherwise 0.
  - entry_idx = ptr.
- Grant taken when selector_enb & pop_ready:
  - base = (cand==ptr) ? used : 0.
  - If base+1 == tbl_w[cand]: ptr=(cand+1) mod TABLE_SIZE, used=0.
  - Else: ptr=cand, used=base+1.
- selector_enb=1 but pop_ready=0: state holds and the grant is not counted. selector stays stable while buf_empty is stable.
- No grant taken while enb=1 and rst=1:
  - WORK_CONSERVING=1 with no eligible entry: state holds.
  - WORK_CONSERVING=0 with the ptr entry ineligible: ptr advances by 1 (wrapping) and used=0.
  - Otherwise (eligible but pop_ready=0): state holds.
- enb=0: state holds and selector_enb=0.
- All weights 0: selector_enb is never 1. In non-work-conserving mode ptr free-runs.
- Width rules:
  - A weight of 2^WEIGHT_BITS-1 gives the full quota; used never exceeds tbl_w-1.
  - A queue index out of range of QUEUE_QUANTITY is not checked. Software guarantees indices are in range.
- Reset mid-operation overrides everything, including cfg_load and enb.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with all queues non-empty, enb=1 -> selector_enb=0, selector=0, entry_idx=0. On release, the first grant is entry 0.
2. Weighted order: weights {3,1,2,1,0,0,0,0}, selecciones {0,1,2,3,0,0,0,0}, all non-empty, pop_ready=1 -> selector sequence 0,0,0,1,2,2,3,0,0,0. Entries 4-7 are skipped, and the pointer wraps to entry 0.
3. Work-conserving skip: same table, buf_empty[1]=1, WORK_CONSERVING=1 -> 0,0,0,2,2,3,0… with no idle cycle. With WORK_CONSERVING=0 -> 0,0,0, then one cycle with selector_enb=0, then 2,2,3.
4. Backpressure: pop_ready=0 for 3 cycles after the 2nd grant of entry 0 -> selector_enb=1 and selector=0 are held. After release, exactly one more grant of queue 0 follows, then queue 1.
5. Runtime reload: assert cfg_load for 1 cycle mid-entry-2 with new weights {1,1,1,1,1,1,1,1}, selecciones {3,2,1,0,3,2,1,0} -> selector_enb=0 that cycle, then 3,2,1,0,3,2,1,0,3.
6. All-disabled / enable gating: all weights 0 -> selector_enb stays 0 for 20 cycles. Then load valid weights and drop enb for 5 cycles -> no grants and entry_idx frozen.
